fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one fp_adder.
REQ-002 Parameter CNT_W, default 16: width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  per-requester grant; handshake when req_valid[i] && req_ready[i].
REQ-007 req_a, req_b  input  N_REQ x 32  IEEE-754 single operands, held stable while req_valid[i] is high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_sum  output  32  IEEE-754 single sum, equal to fp_adder output for the granted operands.
REQ-011 rsp_id  output  $clog2(N_REQ)  index of the requester that owns rsp_sum.
REQ-012 busy  output  1  high when either pipeline stage holds a valid entry.
REQ-013 op_count  output  CNT_W  number of completed response handshakes, wrapping modulo 2^CNT_W.

Function
REQ-014 Two-stage pipeline: S1 operand register (op_valid, op_a, op_b, op_id) drives fp_adder; S2 result register (rsp_valid, rsp_sum, rsp_id) captures fp_adder.s.
REQ-015 S2 advance: adv2 = !rsp_valid || rsp_ready; S2 loads S1 contents when adv2, with rsp_valid <= op_valid.
REQ-016 S1 advance: adv1 = !op_valid || adv2; S1 loads the granted request when adv1, with op_valid <= 1 if any grant, else 0.
REQ-017 Latency: request handshake in cycle T produces rsp_valid in cycle T+2 when rsp_ready is held high.
REQ-018 Throughput: one accepted request per cycle when rsp_ready is held high.
REQ-019 Arbitration is round-robin: at most one req_ready bit is high per cycle, only when adv1 and the matching req_valid are high.
REQ-020 The priority pointer starts at requester 0; after a grant to i it moves to (i+1) mod N_REQ; with no grant it is unchanged.
REQ-021 req_ready may depend combinationally on req_valid and rsp_ready; no other input-to-output combinational path exists.
REQ-022 Backpressure: with rsp_ready low and both stages full, all req_ready are 0 and S1/S2 contents hold unchanged.
REQ-023 Simultaneous S2 drain and S1 refill in one cycle are legal and lose no entry.
REQ-024 op_count increments on each rsp_valid && rsp_ready cycle and wraps from all-ones to 0.
REQ-025 NaN/Inf operands are passed through to fp_adder without special handling; the arbiter never alters data bits.

Reset
REQ-026 On rst_n low, asynchronously: op_valid=0, rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0, priority pointer=0, and req_ready=0.
REQ-027 Reset asserted mid-operation discards all in-flight entries without producing a response; the first cycle after release accepts requests normally.

Structure
REQ-028 Package fp_arb_pkg holds FP_W=32, typedef fp32_t, and the default N_REQ and CNT_W constants.
REQ-029 Round-robin grant logic is a separate sub-module rr_arbiter (req, advance enable, grant one-hot, pointer state).
REQ-030 fp_adder is instantiated once and unmodified (ports a, b, s).

Verification
REQ-031 Single request: req0 with a=3F800001, b=BF800000, rsp_ready=1 -> rsp_valid at T+2, rsp_sum=34000000, rsp_id=0, op_count=1.
REQ-032 All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; sums match fp_adder golden values, e.g. 440d491c+4d064db7=4d064dda.
REQ-033 rsp_ready=0 for 5 cycles with requests pending -> after two accepts, req_ready=0 and rsp_sum is stable; releasing rsp_ready delivers both results in order with no loss.
REQ-034 Reset pulse with both stages full -> rsp_valid=0 and op_count=0 immediately; no stale result follows release.
REQ-035 Only req2 valid, then req1 and req3 valid together after the req2 grant -> req3 is granted before req1.
REQ-036 op_count preset to FFFF (CNT_W=16) plus one completed response -> op_count=0000.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types and default sizing for the round-robin fp_adder arbiter.
package fp_arb_pkg;

    localparam int FP_W      = 32;
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef logic [FP_W-1:0] fp32_t;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// subnormal in/out, Inf/NaN propagation (NaN results are the canonical quiet NaN).
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    logic        a_nan, b_nan, a_inf, b_inf, swap, hit, rnd;
    logic [31:0] x, y;
    logic [8:0]  ex, ey, e, d, ef;
    logic [26:0] mx, my, my_sh, m;
    logic [27:0] acc;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic [22:0] mant;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        // x is the larger magnitude, so the aligned subtraction never goes negative
        swap = (b[30:0] > a[30:0]);
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = {1'b0, (x[30:23] == 8'd0) ? 8'd1 : x[30:23]};
        ey   = {1'b0, (y[30:23] == 8'd0) ? 8'd1 : y[30:23]};
        mx   = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        my   = {(y[30:23] != 8'd0), y[22:0], 3'b000};
        d    = ex - ey;

        if (d >= 9'd27) begin
            my_sh = {26'd0, (my != 27'd0)};
        end else begin
            my_sh = (my >> d[4:0])
                  | {26'd0, ((my & ((27'd1 << d[4:0]) - 27'd1)) != 27'd0)};
        end

        if (x[31] == y[31]) acc = {1'b0, mx} + {1'b0, my_sh};
        else                acc = {1'b0, mx} - {1'b0, my_sh};

        m   = acc[26:0];
        e   = ex;
        lz  = 5'd0;
        hit = 1'b0;
        if (acc[27]) begin
            m = acc[27:1] | {26'd0, acc[0]};
            e = ex + 9'd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (m[i])      hit = 1'b1;
                else if (!hit) lz  = lz + 5'd1;
            end
            // Left shift stops at the minimum exponent, leaving a subnormal
            if ({4'd0, lz} >= ex) begin
                m = m << (ex - 9'd1);
                e = 9'd1;
            end else begin
                m = m << lz;
                e = ex - {4'd0, lz};
            end
        end

        rnd = m[2] & (m[3] | m[1] | m[0]);
        mr  = {1'b0, m[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            ef   = e + 9'd1;
            mant = mr[23:1];
        end else if (mr[23]) begin
            ef   = e;
            mant = mr[22:0];
        end else begin
            ef   = 9'd0;
            mant = mr[22:0];
        end

        if (ef >= 9'd255) s = {x[31], 8'hFF, 23'd0};
        else              s = {x[31], ef[7:0], mant};

        if (acc == 28'd0) s = {x[31] & y[31], 31'd0};

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) s = 32'h7FC0_0000;
        else if (a_inf) s = a;
        else if (b_inf) s = b;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the pointer names the highest-priority requester.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             hit;

    // Two passes: requesters at/after the pointer first, then the wrapped ones
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !hit && req[i] && (i >= int'(ptr_q))) begin
                hit      = 1'b1;
                grant[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : IDX_W'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !hit && req[i] && (i < int'(ptr_q))) begin
                hit      = 1'b1;
                grant[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// N requesters share one fp_adder through a round-robin arbiter and a
// two-stage (operand / result) valid-ready pipeline.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][FP_W-1:0]  req_a,
    input  logic [N_REQ-1:0][FP_W-1:0]  req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [FP_W-1:0]             rsp_sum,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);

    logic             op_valid_q, op_valid_d;
    fp32_t            op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    fp32_t            rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             adv1, adv2, arb_en, any_grant, rsp_fire;
    logic [N_REQ-1:0] grant;
    fp32_t            sel_a, sel_b, add_s;
    logic [ID_W-1:0]  sel_id;

    assign adv2     = !rsp_valid_q || rsp_ready;
    assign adv1     = !op_valid_q || adv2;
    assign rsp_fire = rsp_valid_q && rsp_ready;
    // No grant can be offered while reset is held
    assign arb_en   = adv1 && rst_n;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i];
                sel_b  = req_b[i];
                sel_id = ID_W'(i);
            end
        end
    end

    fp_adder u_add (
        .a (op_a_q),
        .b (op_b_q),
        .s (add_s)
    );

    always_comb begin
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (adv1) begin
            op_valid_d = any_grant;
            if (any_grant) begin
                op_a_d  = sel_a;
                op_b_d  = sel_b;
                op_id_d = sel_id;
            end
        end
        if (adv2) begin
            rsp_valid_d = op_valid_q;
            rsp_sum_d   = add_s;
            rsp_id_d    = op_id_q;
        end
        op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, rsp_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = op_valid_q || rsp_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: latency, round-robin order, backpressure,
// reset flush, pointer rotation and counter wrap, with hand-computed sums.
module tb_fp_add_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][31:0] req_a;
    logic [3:0][31:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_sum;
    logic [1:0]       rsp_id;
    logic             busy;
    logic [15:0]      op_count;

    int n_checks = 0;
    int n_pass   = 0;

    fp_add_arbiter #(.N_REQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] exp_sum [4];
    logic [3:0]  one_hot;
    int          k;
    int          cyc;

    initial begin
        exp_sum[0] = 32'h4000_0000;   // 1 + 1
        exp_sum[1] = 32'h4D06_4DDA;   // 440d491c + 4d064db7
        exp_sum[2] = 32'h40A0_0000;   // 2 + 3
        exp_sum[3] = 32'h40E0_0000;   // 3 + 4

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_ready",    32'(req_ready), 32'h0);
        chk("rst_rsp_vld",  32'(rsp_valid), 32'h0);
        chk("rst_rsp_sum",  rsp_sum,        32'h0);
        chk("rst_rsp_id",   32'(rsp_id),    32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_op_count", 32'(op_count),  32'h0);
        tick();
        req_valid = 4'h0;
        rst_n     = 1'b1;

        // Single request latency
        tick();
        req_a[0] = 32'h3F80_0001; req_b[0] = 32'hBF80_0000;
        req_valid = 4'b0001;
        #1; chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1; chk("single_t1_vld", 32'(rsp_valid), 32'h0);
        chk("single_t1_busy", 32'(busy), 32'h1);
        tick(); #1;
        chk("single_t2_vld", 32'(rsp_valid), 32'h1);
        chk("single_sum",    rsp_sum,        32'h3400_0000);
        chk("single_id",     32'(rsp_id),    32'h0);
        tick(); #1;
        chk("single_t3_vld", 32'(rsp_valid), 32'h0);
        chk("single_count",  32'(op_count),  32'h1);

        // All four requesters continuously valid
        tick();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h3F80_0000;
        req_a[1] = 32'h440D_491C; req_b[1] = 32'h4D06_4DB7;
        req_a[2] = 32'h4000_0000; req_b[2] = 32'h4040_0000;
        req_a[3] = 32'h4040_0000; req_b[3] = 32'h4080_0000;
        for (int c = 0; c < 7; c++) begin
            tick();
            req_valid = (c < 5) ? 4'hF : 4'h0;
            #1;
            if (c < 5) begin
                one_hot = 4'b0001 << (c % 4);
                chk($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(one_hot));
            end
            if (c >= 2) begin
                k = (c - 2) % 4;
                chk($sformatf("rr_vld_c%0d", c), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr_id_c%0d", c),  32'(rsp_id),    32'(k));
                chk($sformatf("rr_sum_c%0d", c), rsp_sum,        exp_sum[k]);
            end
        end

        // Backpressure: pointer is at 1 here
        tick();
        rsp_ready = 1'b0;
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h4000_0000;
        req_a[1] = 32'h4000_0000; req_b[1] = 32'h4040_0000;
        req_valid = 4'b0011;
        #1; chk("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0001;
        #1; chk("bp_grant0", 32'(req_ready), 32'h1);
        tick();
        req_a[0] = 32'h4040_0000; req_b[0] = 32'h4080_0000;
        #1;
        for (int c = 2; c < 7; c++) begin
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp_vld_c%0d", c),   32'(rsp_valid), 32'h1);
            chk($sformatf("bp_sum_c%0d", c),   rsp_sum,        32'h40A0_0000);
            tick(); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_refill",   32'(req_ready), 32'h1);
        chk("bp_out1_sum", rsp_sum,        32'h40A0_0000);
        chk("bp_out1_id",  32'(rsp_id),    32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("bp_out2_sum", rsp_sum,     32'h4040_0000);
        chk("bp_out2_id",  32'(rsp_id), 32'h0);
        tick(); #1;
        chk("bp_out3_vld", 32'(rsp_valid), 32'h1);
        chk("bp_out3_sum", rsp_sum,        32'h40E0_0000);
        tick(); #1;
        chk("bp_idle_vld",  32'(rsp_valid), 32'h0);
        chk("bp_idle_busy", 32'(busy),      32'h0);
        chk("bp_count",     32'(op_count),  32'h8);

        // Reset with both stages full
        tick();
        rsp_ready = 1'b0;
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h3F80_0000;
        req_valid = 4'b0001;
        #1; chk("rf_acc1", 32'(req_ready), 32'h1);
        tick(); #1;
        chk("rf_acc2", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("rf_full_vld", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rf_rst_vld",   32'(rsp_valid), 32'h0);
        chk("rf_rst_count", 32'(op_count),  32'h0);
        chk("rf_rst_busy",  32'(busy),      32'h0);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk($sformatf("rf_nostale_c%0d", c), 32'(rsp_valid), 32'h0);
        end

        // Pointer rotation: req3 beats req1 after a grant to req2
        tick();
        req_a[2] = 32'h7F80_0000; req_b[2] = 32'h3F80_0000;
        req_valid = 4'b0100;
        #1; chk("ptr_g2", 32'(req_ready), 32'h4);
        tick();
        req_a[1] = 32'h3F80_0001; req_b[1] = 32'hBF80_0000;
        req_a[3] = 32'h440D_491C; req_b[3] = 32'h4D06_4DB7;
        req_valid = 4'b1010;
        #1; chk("ptr_g3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("ptr_g1",     32'(req_ready), 32'h2);
        chk("ptr_r2_id",  32'(rsp_id),    32'h2);
        chk("ptr_r2_sum", rsp_sum,        32'h7F80_0000);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("ptr_r3_id",  32'(rsp_id), 32'h3);
        chk("ptr_r3_sum", rsp_sum,     32'h4D06_4DDA);
        tick(); #1;
        chk("ptr_r1_id",  32'(rsp_id), 32'h1);
        chk("ptr_r1_sum", rsp_sum,     32'h3400_0000);
        tick(); #1;
        chk("ptr_count", 32'(op_count), 32'h3);

        // Counter wrap under continuous streaming
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h3F80_0000;
        req_valid = 4'b0001;
        cyc = 0;
        while (op_count != 16'hFFFF && cyc < 70000) begin
            tick();
            cyc++;
        end
        chk("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
        tick(); #1;
        chk("wrap_zero", 32'(op_count), 32'h0);
        chk("wrap_sum",  rsp_sum,       32'h4000_0000);
        req_valid = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
